// File: rtl/divider_arbiter.sv
// ---------------------------------------------------------------------------
// divider_arbiter
//
// Purpose:
//   Shares one external pipelined divider between NREQ requesters. Each cycle
//   it grants at most one request, in round-robin order, and registers that
//   request's operands into the divider. A tag pipe as deep as the divider
//   tracks the requester ID and the divide-by-zero flag of each operation. It
//   pairs each divider result with its tag and returns it as a one-cycle
//   response. A result that arrives without a matching tag, or a tag that
//   arrives without a result, sets a sticky error flag.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset
//   arb_en            enables new grants; operations in flight always drain
//   req_valid         per-requester request
//   req_dividend      packed dividends, requester i at [i*N +: N]
//   req_divisor       packed divisors,  requester i at [i*M +: M]
//   req_ready         one-hot grant (combinational)
//   div_enable        registered issue strobe to the divider
//   div_dividend      registered dividend to the divider
//   div_divisor       registered divisor to the divider
//   div_ready         divider result valid
//   div_merchant      divider quotient
//   div_remainder     divider remainder
//   rsp_valid         one-cycle response strobe
//   rsp_id            requester that owns the response
//   rsp_merchant      quotient (0 on divide-by-zero)
//   rsp_remainder     remainder (0 on divide-by-zero)
//   rsp_dz            the divisor was zero
//   busy              an operation is in the issue register, tag pipe or
//                     response register
//   err_tag           sticky result/tag misalignment flag
// ---------------------------------------------------------------------------
module divider_arbiter #(
    parameter int NREQ = 4,
    parameter int N    = 5,
    parameter int M    = 3,
    parameter int LAT  = N,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                arb_en,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*N-1:0]   req_dividend,
    input  logic [NREQ*M-1:0]   req_divisor,
    output logic [NREQ-1:0]     req_ready,
    output logic                div_enable,
    output logic [N-1:0]        div_dividend,
    output logic [M-1:0]        div_divisor,
    input  logic                div_ready,
    input  logic [N-1:0]        div_merchant,
    input  logic [M-1:0]        div_remainder,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [N-1:0]        rsp_merchant,
    output logic [M-1:0]        rsp_remainder,
    output logic                rsp_dz,
    output logic                busy,
    output logic                err_tag
);

    // One extra bit so that rr + offset can be reduced modulo NREQ
    // without overflowing when NREQ is not a power of two.
    localparam int              IDX_W  = IDW + 1;
    localparam logic [IDW:0]    NREQ_W = IDX_W'(NREQ);

    // Round-robin pointer
    logic [IDW-1:0]             rr_q, rr_d;

    // Issue stage
    logic                       div_enable_q, div_enable_d;
    logic [N-1:0]               div_dividend_q, div_dividend_d;
    logic [M-1:0]               div_divisor_q, div_divisor_d;
    logic [IDW-1:0]             issue_id_q, issue_id_d;

    // Tag pipe; stage LAT-1 lines up with div_ready
    logic [LAT-1:0]             tag_valid_q, tag_valid_d;
    logic [LAT-1:0][IDW-1:0]    tag_id_q, tag_id_d;
    logic [LAT-1:0]             tag_dz_q, tag_dz_d;

    // Response stage
    logic                       rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]             rsp_id_q, rsp_id_d;
    logic [N-1:0]               rsp_merchant_q, rsp_merchant_d;
    logic [M-1:0]               rsp_remainder_q, rsp_remainder_d;
    logic                       rsp_dz_q, rsp_dz_d;
    logic                       err_tag_q, err_tag_d;

    // Arbiter intermediates
    logic [IDW:0]               scan;
    logic [IDW:0]               next_idx;
    logic [IDW-1:0]             grant_idx;
    logic                       grant_found;
    logic                       grant_ok;
    logic                       transfer;

    // Tag pipe output intermediates
    logic                       tag_out_valid;
    logic                       rsp_hit;

    // Scan the requesters starting at the round-robin pointer and take the
    // first one that is asking. The grant is withheld while arb_en is low
    // or reset is asserted.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, rr_q} + IDX_W'(k);
            if (scan >= NREQ_W) begin
                scan = scan - NREQ_W;
            end
            if (!grant_found && req_valid[scan[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IDW-1:0];
            end
        end
        grant_ok  = grant_found & arb_en & rst_n;
        req_ready = '0;
        if (grant_ok) begin
            req_ready[grant_idx] = 1'b1;
        end
        transfer = |(req_valid & req_ready);
    end

    // The pointer moves one past the winner on a transfer and holds
    // otherwise.
    always_comb begin
        rr_d     = rr_q;
        next_idx = {1'b0, grant_idx} + IDX_W'(1);
        if (transfer) begin
            if (next_idx == NREQ_W) begin
                rr_d = '0;
            end else begin
                rr_d = next_idx[IDW-1:0];
            end
        end
    end

    // The issue register captures the winner's operands and ID. The strobe
    // is high only for the cycle after a transfer; the operands hold otherwise.
    always_comb begin
        div_enable_d   = transfer;
        div_dividend_d = div_dividend_q;
        div_divisor_d  = div_divisor_q;
        issue_id_d     = issue_id_q;
        if (transfer) begin
            div_dividend_d = req_dividend[int'(grant_idx) * N +: N];
            div_divisor_d  = req_divisor[int'(grant_idx) * M +: M];
            issue_id_d     = grant_idx;
        end
    end

    // Stage 0 loads while div_enable is high, the same cycle that the
    // divider samples the operands. The result therefore pops out of the
    // last stage together with div_ready.
    always_comb begin
        tag_valid_d    = '0;
        tag_id_d       = '0;
        tag_dz_d       = '0;
        tag_valid_d[0] = div_enable_q;
        tag_id_d[0]    = issue_id_q;
        tag_dz_d[0]    = (div_divisor_q == '0);
        for (int s = 1; s < LAT; s++) begin
            tag_valid_d[s] = tag_valid_q[s-1];
            tag_id_d[s]    = tag_id_q[s-1];
            tag_dz_d[s]    = tag_dz_q[s-1];
        end
    end

    // A response is registered only when a result and a valid tag arrive
    // together. Any disagreement between them is latched into err_tag and
    // gives no response.
    always_comb begin
        tag_out_valid   = tag_valid_q[LAT-1];
        rsp_hit         = div_ready & tag_out_valid;
        rsp_valid_d     = rsp_hit;
        rsp_id_d        = rsp_id_q;
        rsp_merchant_d  = rsp_merchant_q;
        rsp_remainder_d = rsp_remainder_q;
        rsp_dz_d        = rsp_dz_q;
        err_tag_d       = err_tag_q | (div_ready ^ tag_out_valid);
        if (rsp_hit) begin
            rsp_id_d        = tag_id_q[LAT-1];
            rsp_dz_d        = tag_dz_q[LAT-1];
            rsp_merchant_d  = tag_dz_q[LAT-1] ? '0 : div_merchant;
            rsp_remainder_d = tag_dz_q[LAT-1] ? '0 : div_remainder;
        end
    end

    // All state registers. Reset discards any work in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q            <= '0;
            div_enable_q    <= 1'b0;
            div_dividend_q  <= '0;
            div_divisor_q   <= '0;
            issue_id_q      <= '0;
            tag_valid_q     <= '0;
            tag_id_q        <= '0;
            tag_dz_q        <= '0;
            rsp_valid_q     <= 1'b0;
            rsp_id_q        <= '0;
            rsp_merchant_q  <= '0;
            rsp_remainder_q <= '0;
            rsp_dz_q        <= 1'b0;
            err_tag_q       <= 1'b0;
        end else begin
            rr_q            <= rr_d;
            div_enable_q    <= div_enable_d;
            div_dividend_q  <= div_dividend_d;
            div_divisor_q   <= div_divisor_d;
            issue_id_q      <= issue_id_d;
            tag_valid_q     <= tag_valid_d;
            tag_id_q        <= tag_id_d;
            tag_dz_q        <= tag_dz_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_id_q        <= rsp_id_d;
            rsp_merchant_q  <= rsp_merchant_d;
            rsp_remainder_q <= rsp_remainder_d;
            rsp_dz_q        <= rsp_dz_d;
            err_tag_q       <= err_tag_d;
        end
    end

    // Output drive; busy covers every place an operation can be held.
    assign div_enable    = div_enable_q;
    assign div_dividend  = div_dividend_q;
    assign div_divisor   = div_divisor_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_merchant  = rsp_merchant_q;
    assign rsp_remainder = rsp_remainder_q;
    assign rsp_dz        = rsp_dz_q;
    assign err_tag       = err_tag_q;
    assign busy          = div_enable_q | (|tag_valid_q) | rsp_valid_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// ---------------------------------------------------------------------------
// tb_divider_arbiter
//
// Purpose:
//   Self-checking bench for divider_arbiter. It includes a simple stand-in
//   for the external pipelined divider and a reference model of expected
//   grants and responses. The model uses round-robin rules and plain
//   arithmetic.
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_divider_arbiter;

    localparam int NREQ = 4;
    localparam int N    = 5;
    localparam int M    = 3;
    localparam int LAT  = 5;
    localparam int IDW  = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                arb_en = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ*N-1:0]   req_dividend = '0;
    logic [NREQ*M-1:0]   req_divisor = '0;
    logic [NREQ-1:0]     req_ready;
    logic                div_enable;
    logic [N-1:0]        div_dividend;
    logic [M-1:0]        div_divisor;
    logic                div_ready;
    logic [N-1:0]        div_merchant;
    logic [M-1:0]        div_remainder;
    logic                rsp_valid;
    logic [IDW-1:0]      rsp_id;
    logic [N-1:0]        rsp_merchant;
    logic [M-1:0]        rsp_remainder;
    logic                rsp_dz;
    logic                busy;
    logic                err_tag;
    logic                inject = 1'b0;

    typedef struct {
        int id;
        int q;
        int r;
        int dz;
        int cyc;
    } rsp_t;

    rsp_t            exp_q[$];
    rsp_t            obs_q[$];
    int              n_checks = 0;
    int              n_pass = 0;
    int              cyc = 0;
    int              m_rr = 0;
    logic [N-1:0]    a_arr[NREQ];
    logic [M-1:0]    b_arr[NREQ];

    divider_arbiter #(.NREQ(NREQ), .N(N), .M(M), .LAT(LAT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
        .req_ready(req_ready),
        .div_enable(div_enable), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_ready(div_ready), .div_merchant(div_merchant), .div_remainder(div_remainder),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_merchant(rsp_merchant),
        .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz), .busy(busy), .err_tag(err_tag)
    );

    // 10 ns clock and a free-running cycle counter used to timestamp events
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the external divider: LAT-deep pipeline, cleared by its
    // own reset. It returns all-ones for a zero divisor, so the arbiter's
    // zero forcing is visible.
    logic [LAT-1:0]          dv_v;
    logic [LAT-1:0][N-1:0]   dv_a;
    logic [LAT-1:0][M-1:0]   dv_b;
    logic [N-1:0]            dv_bx;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dv_v <= '0;
            dv_a <= '0;
            dv_b <= '0;
        end else begin
            dv_v <= {dv_v[LAT-2:0], div_enable};
            dv_a <= {dv_a[LAT-2:0], div_dividend};
            dv_b <= {dv_b[LAT-2:0], div_divisor};
        end
    end
    assign dv_bx         = {{(N-M){1'b0}}, dv_b[LAT-1]};
    assign div_ready     = dv_v[LAT-1] | inject;
    assign div_merchant  = (dv_bx == '0) ? '1 : dv_a[LAT-1] / dv_bx;
    assign div_remainder = (dv_bx == '0) ? '1 : M'(dv_a[LAT-1] % dv_bx);

    // Response recorder, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            rsp_t o;
            o.id  = int'(rsp_id);
            o.q   = int'(rsp_merchant);
            o.r   = int'(rsp_remainder);
            o.dz  = int'(rsp_dz);
            o.cyc = cyc;
            obs_q.push_back(o);
        end
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Reference model: first requesting index scanning from rr, modulo NREQ
    function automatic int model_grant(input logic [NREQ-1:0] v, input logic en, input int rr);
        if (!en) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(rr + k) % NREQ]) return (rr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input int g);
        logic [NREQ-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    // Expected response of an operation transferred in cycle t
    function automatic void model_push(input int id, input int a, input int b, input int t);
        rsp_t e;
        e.id  = id;
        e.cyc = t + 2 + LAT;
        if (b == 0) begin
            e.q = 0; e.r = 0; e.dz = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 0;
        end
        exp_q.push_back(e);
    endfunction

    // Drive the operand arrays onto the packed request buses
    task automatic applyStimulus();
        for (int i = 0; i < NREQ; i++) begin
            req_dividend[i*N +: N] = a_arr[i];
            req_divisor[i*M +: M]  = b_arr[i];
        end
    endtask

    task automatic randomize_ops(input int i);
        a_arr[i] = N'($urandom_range(0, (1 << N) - 1));
        b_arr[i] = M'($urandom_range(0, (1 << M) - 1));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Poll mid-cycle until n responses are recorded or the budget expires
    task automatic wait_rsp(input int n, output bit ok);
        for (int i = 0; i < 100 && obs_q.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        arb_en = 1'b1;
        inject = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        m_rr = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Reset values, with requests already pending to show the grant is held off
    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) randomize_ops(i);
        applyStimulus();
        arb_en = 1'b1;
        req_valid = '1;
        #3;
        n_checks++;
        if ({req_ready, div_enable, div_dividend, div_divisor, rsp_valid, rsp_id,
             rsp_merchant, rsp_remainder, rsp_dz, busy, err_tag} !== '0)
            $display("[TB] FAIL reset_outputs: got rdy=%b en=%b a=%0d b=%0d rv=%b busy=%b err=%b want all zero",
                     req_ready, div_enable, div_dividend, div_divisor, rsp_valid, busy, err_tag);
        else n_pass++;
        step();
        step();
        req_valid = '0;
        rst_n = 1'b1;
        m_rr = 0;
        #1;
        n_checks++;
        if (req_ready !== '0) $display("[TB] FAIL reset_idle_ready: got %b want 0000", req_ready);
        else n_pass++;
    endtask

    // Requester 2 sends 23/5; check grant, issue registers and response timing
    task automatic test_single();
        int  t;
        bit  ok;
        rsp_t e, o;
        step();
        a_arr[2] = 5'd23;
        b_arr[2] = 3'd5;
        applyStimulus();
        req_valid = 4'b0100;
        #1;
        t = cyc;
        n_checks++;
        if (req_ready !== onehot(model_grant(req_valid, arb_en, m_rr)))
            $display("[TB] FAIL single_grant: got %b want %b", req_ready, onehot(model_grant(req_valid, arb_en, m_rr)));
        else n_pass++;
        model_push(2, 23, 5, t);
        m_rr = 3;
        step();
        req_valid = '0;
        n_checks++;
        if ({div_enable, div_dividend, div_divisor} !== {1'b1, 5'd23, 3'd5})
            $display("[TB] FAIL single_issue: got en=%b a=%0d b=%0d want en=1 a=23 b=5", div_enable, div_dividend, div_divisor);
        else n_pass++;
        step();
        n_checks++;
        if (div_enable !== 1'b0) $display("[TB] FAIL single_issue_pulse: got %b want 0", div_enable);
        else n_pass++;
        wait_rsp(1, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL single_timeout: got %0d responses want 1", obs_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.id !== e.id || o.q !== e.q || o.r !== e.r || o.dz !== e.dz || o.cyc !== e.cyc)
                $display("[TB] FAIL single_rsp: got id=%0d q=%0d r=%0d dz=%0d cyc=%0d want id=%0d q=%0d r=%0d dz=%0d cyc=%0d",
                         o.id, o.q, o.r, o.dz, o.cyc, e.id, e.q, e.r, e.dz, e.cyc);
            else n_pass++;
        end
        step();
    endtask

    // All four requesters hold requests from reset; one grant per cycle in rotation
    task automatic test_contention();
        int  g;
        bit  ok;
        rsp_t e, o;
        do_reset();
        for (int i = 0; i < NREQ; i++) randomize_ops(i);
        req_valid = '1;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            #1;
            g = model_grant(req_valid, arb_en, m_rr);
            n_checks++;
            if (req_ready !== onehot(g))
                $display("[TB] FAIL contention_grant%0d: got %b want %b", i, req_ready, onehot(g));
            else n_pass++;
            if (g >= 0) begin
                model_push(g, int'(a_arr[g]), int'(b_arr[g]), cyc);
                m_rr = (g + 1) % NREQ;
            end
            step();
            if (g >= 0) randomize_ops(g);
        end
        req_valid = '0;
        wait_rsp(12, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL contention_timeout: got %0d responses want 12", obs_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.id !== e.id || o.q !== e.q || o.r !== e.r || o.dz !== e.dz || o.cyc !== e.cyc)
                $display("[TB] FAIL contention_rsp: got id=%0d q=%0d r=%0d dz=%0d cyc=%0d want id=%0d q=%0d r=%0d dz=%0d cyc=%0d",
                         o.id, o.q, o.r, o.dz, o.cyc, e.id, e.q, e.r, e.dz, e.cyc);
            else n_pass++;
        end
        step();
    endtask

    // Requester 1 sends 9/0 then 31/7 back to back
    task automatic test_divzero();
        int  g;
        bit  ok;
        rsp_t e, o;
        for (int i = 0; i < 2; i++) begin
            a_arr[1] = (i == 0) ? 5'd9 : 5'd31;
            b_arr[1] = (i == 0) ? 3'd0 : 3'd7;
            applyStimulus();
            req_valid = 4'b0010;
            #1;
            g = model_grant(req_valid, arb_en, m_rr);
            n_checks++;
            if (req_ready !== onehot(g)) $display("[TB] FAIL divzero_grant%0d: got %b want %b", i, req_ready, onehot(g));
            else n_pass++;
            model_push(1, int'(a_arr[1]), int'(b_arr[1]), cyc);
            m_rr = (g + 1) % NREQ;
            step();
        end
        req_valid = '0;
        wait_rsp(2, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL divzero_timeout: got %0d responses want 2", obs_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.id !== e.id || o.q !== e.q || o.r !== e.r || o.dz !== e.dz || o.cyc !== e.cyc)
                $display("[TB] FAIL divzero_rsp: got id=%0d q=%0d r=%0d dz=%0d cyc=%0d want id=%0d q=%0d r=%0d dz=%0d cyc=%0d",
                         o.id, o.q, o.r, o.dz, o.cyc, e.id, e.q, e.r, e.dz, e.cyc);
            else n_pass++;
        end
        step();
    endtask

    // Three operations in flight, then arb_en drops with requests pending
    task automatic test_arb_en();
        int  g;
        bit  ok;
        rsp_t e, o;
        for (int i = 0; i < NREQ; i++) randomize_ops(i);
        req_valid = '1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            #1;
            g = model_grant(req_valid, arb_en, m_rr);
            n_checks++;
            if (req_ready !== onehot(g)) $display("[TB] FAIL arben_grant%0d: got %b want %b", i, req_ready, onehot(g));
            else n_pass++;
            model_push(g, int'(a_arr[g]), int'(b_arr[g]), cyc);
            m_rr = (g + 1) % NREQ;
            step();
            randomize_ops(g);
        end
        applyStimulus();
        arb_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (req_ready !== '0) $display("[TB] FAIL arben_hold%0d: got %b want 0000", i, req_ready);
            else n_pass++;
            step();
        end
        wait_rsp(3, ok);
        n_checks++;
        if (!ok) $display("[TB] FAIL arben_timeout: got %0d responses want 3", obs_q.size());
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL arben_busy_last: got %b want 1", busy);
        else n_pass++;
        @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL arben_busy_idle: got %b want 0", busy);
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.id !== e.id || o.q !== e.q || o.r !== e.r || o.dz !== e.dz || o.cyc !== e.cyc)
                $display("[TB] FAIL arben_rsp: got id=%0d q=%0d r=%0d dz=%0d cyc=%0d want id=%0d q=%0d r=%0d dz=%0d cyc=%0d",
                         o.id, o.q, o.r, o.dz, o.cyc, e.id, e.q, e.r, e.dz, e.cyc);
            else n_pass++;
        end
        step();
        arb_en = 1'b1;
        #1;
        g = model_grant(req_valid, arb_en, m_rr);
        n_checks++;
        if (req_ready !== onehot(g)) $display("[TB] FAIL arben_resume: got %b want %b", req_ready, onehot(g));
        else n_pass++;
        model_push(g, int'(a_arr[g]), int'(b_arr[g]), cyc);
        m_rr = (g + 1) % NREQ;
        step();
        req_valid = '0;
        wait_rsp(1, ok);
        n_checks++;
        if (!ok || obs_q.size() == 0) $display("[TB] FAIL arben_resume_timeout: got %0d responses want 1", obs_q.size());
        else begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            if (o.id !== e.id || o.q !== e.q || o.r !== e.r || o.dz !== e.dz || o.cyc !== e.cyc)
                $display("[TB] FAIL arben_resume_rsp: got id=%0d q=%0d r=%0d cyc=%0d want id=%0d q=%0d r=%0d cyc=%0d",
                         o.id, o.q, o.r, o.cyc, e.id, e.q, e.r, e.cyc);
            else n_pass++;
        end
        step();
    endtask

    // Reset two cycles after issuing two operations
    task automatic test_reset_midflight();
        for (int i = 0; i < NREQ; i++) begin
            a_arr[i] = N'($urandom_range(1, (1 << N) - 1));
            b_arr[i] = M'($urandom_range(1, (1 << M) - 1));
        end
        applyStimulus();
        req_valid = '1;
        step();
        step();
        req_valid = '0;
        step();
        step();
        rst_n = 1'b0;
        req_valid = '1;
        #1;
        n_checks++;
        if ({req_ready, div_enable, div_dividend, div_divisor, rsp_valid, rsp_id,
             rsp_merchant, rsp_remainder, rsp_dz, busy, err_tag} !== '0)
            $display("[TB] FAIL midflight_reset_outputs: got rdy=%b en=%b a=%0d b=%0d rv=%b busy=%b err=%b want all zero",
                     req_ready, div_enable, div_dividend, div_divisor, rsp_valid, busy, err_tag);
        else n_pass++;
        req_valid = '0;
        exp_q.delete();
        obs_q.delete();
        step();
        rst_n = 1'b1;
        m_rr = 0;
        repeat (2 * LAT) step();
        n_checks++;
        if (obs_q.size() != 0) $display("[TB] FAIL midflight_no_rsp: got %0d responses want 0", obs_q.size());
        else n_pass++;
    endtask

    // Spurious div_ready with an empty tag pipe
    task automatic test_tag();
        inject = 1'b1;
        step();
        inject = 1'b0;
        n_checks++;
        if ({err_tag, rsp_valid} !== 2'b10) $display("[TB] FAIL tag_err_set: got err=%b rv=%b want err=1 rv=0", err_tag, rsp_valid);
        else n_pass++;
        repeat (3) step();
        n_checks++;
        if (err_tag !== 1'b1) $display("[TB] FAIL tag_err_sticky: got %b want 1", err_tag);
        else n_pass++;
        n_checks++;
        if (obs_q.size() != 0) $display("[TB] FAIL tag_no_rsp: got %0d responses want 0", obs_q.size());
        else n_pass++;
        do_reset();
        #1;
        n_checks++;
        if (err_tag !== 1'b0) $display("[TB] FAIL tag_err_clear: got %b want 0", err_tag);
        else n_pass++;
    endtask

    // Random requests, operands and arb_en against the reference model
    task automatic test_random();
        int  g;
        bit  ok;
        rsp_t e, o;
        do_reset();
        for (int i = 0; i < NREQ; i++) randomize_ops(i);
        for (int i = 0; i < 60; i++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            arb_en = ($urandom_range(0, 3) != 0);
            applyStimulus();
            #1;
            g = model_grant(req_valid, arb_en, m_rr);
            n_checks++;
            if (req_ready !== onehot(g)) $display("[TB] FAIL random_grant%0d: got %b want %b", i, req_ready, onehot(g));
            else n_pass++;
            if (g >= 0) begin
                model_push(g, int'(a_arr[g]), int'(b_arr[g]), cyc);
                m_rr = (g + 1) % NREQ;
            end
            step();
            if (g >= 0) randomize_ops(g);
        end
        req_valid = '0;
        arb_en = 1'b1;
        wait_rsp(exp_q.size(), ok);
        n_checks++;
        if (!ok || obs_q.size() != exp_q.size())
            $display("[TB] FAIL random_count: got %0d responses want %0d", obs_q.size(), exp_q.size());
        else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_checks++;
            if (o.id !== e.id || o.q !== e.q || o.r !== e.r || o.dz !== e.dz || o.cyc !== e.cyc)
                $display("[TB] FAIL random_rsp: got id=%0d q=%0d r=%0d dz=%0d cyc=%0d want id=%0d q=%0d r=%0d dz=%0d cyc=%0d",
                         o.id, o.q, o.r, o.dz, o.cyc, e.id, e.q, e.r, e.dz, e.cyc);
            else n_pass++;
        end
        n_checks++;
        if (err_tag !== 1'b0) $display("[TB] FAIL random_err_tag: got %b want 0", err_tag);
        else n_pass++;
    endtask

    // Test sequence
    initial begin
        $display("[TB] starting divider_arbiter bench");
        test_reset();
        test_single();
        test_contention();
        test_divzero();
        test_arb_en();
        test_reset_midflight();
        test_tag();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
